// File: rtl/floatmul_pkg.sv
// floatmul_pkg: shared types, constants and operand helpers for the float32 multiplier.
// Optional build macro FLOATMUL_SUBNORMAL_EN: full subnormal support (otherwise DAZ/FTZ).
package floatmul_pkg;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  localparam logic signed [9:0] FP32_BIAS    = 10'sd127;
  localparam logic signed [9:0] FP32_EXP_MAX = 10'sd255;
  localparam logic [31:0]       FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0]       FP32_INF     = 32'h7F800000;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp_class_e;

  typedef struct packed {
    fp_class_e         cls;
    logic [23:0]       sig;
    logic signed [9:0] exp;
  } unpacked_t;

  typedef struct packed {
    logic              sign;
    fp_class_e         cls_a;
    fp_class_e         cls_b;
    logic signed [9:0] exp;
    logic [47:0]       prod;
  } s1_t;

  typedef struct packed {
    logic        sign;
    fp_class_e   cls_a;
    fp_class_e   cls_b;
    logic [30:0] mag;
  } s2_t;

  function automatic fp_class_e classify(float32_t f);
    return f.exp == 8'hFF ? (f.mant != 23'd0 ? NAN : INF) :
           f.exp == 8'h00 ? (f.mant != 23'd0 ? SUBNORM : ZERO) : NORMAL;
  endfunction

`ifdef FLOATMUL_SUBNORMAL_EN
  function automatic logic [4:0] lzc24(logic [23:0] v);
    logic [4:0] z;
    z = 5'd24;
    for (int i = 0; i < 24; i++) if (v[i]) z = 5'(23 - i);
    return z;
  endfunction
`endif

  // Subnormals are renormalized so the significand always carries its leading one at bit 23.
  function automatic unpacked_t unpack(float32_t f);
    unpacked_t u;
    u.cls = classify(f);
    u.sig = {1'b1, f.mant};
    u.exp = $signed({2'b00, f.exp});
`ifdef FLOATMUL_SUBNORMAL_EN
    if (u.cls == SUBNORM) begin
      logic [4:0] z;
      z = lzc24({1'b0, f.mant});
      u.sig = {1'b0, f.mant} << z;
      u.exp = 10'sd1 - $signed({5'd0, z});
    end
`else
    if (u.cls == SUBNORM) u.cls = ZERO;
`endif
    return u;
  endfunction
endpackage

// File: rtl/floatmul_round.sv
// floatmul_round: normalize, round-to-nearest-even, overflow and underflow of a 48-bit product.
// Ports: prod_i (24x24 significand product), exp_i (biased signed exponent),
//        mag_o (rounded magnitude {exp, mant}, overflow saturates to infinity).
// FLOATMUL_SUBNORMAL_EN selects gradual underflow; otherwise tiny results flush to zero.
module floatmul_round
  import floatmul_pkg::*;
(
  input  logic [47:0]       prod_i,
  input  logic signed [9:0] exp_i,
  output logic [30:0]       mag_o
);
  logic [46:0]       n, t;
  logic signed [9:0] e, e_base, e_out;
  logic              lost, inc;
  logic [32:0]       sum;
`ifdef FLOATMUL_SUBNORMAL_EN
  logic [5:0]        sh;
  logic [94:0]       y;
`endif

  always_comb begin
    n = prod_i[47] ? prod_i[46:0] : {prod_i[45:0], 1'b0};
    e = prod_i[47] ? exp_i + 10'sd1 : exp_i;
`ifdef FLOATMUL_SUBNORMAL_EN
    // Tiny results are denormalized first (hidden one re-inserted) so rounding happens once.
    sh = e > 0 ? 6'd0 : e < -10'sd61 ? 6'd63 : 6'(10'sd1 - e);
    y = 95'({1'b1, n, 48'd0} >> sh);
    t = y[94:48];
    lost = |y[47:0];
    e_base = e > 0 ? e : 10'sd0;
`else
    t = n;
    lost = 1'b0;
    e_base = e;
`endif
    inc = t[23] && (|t[22:0] || lost || t[24]);
    // A mantissa carry ripples into the exponent field, which is the renormalization.
    sum = {e_base, t[46:24]} + {32'd0, inc};
    e_out = sum[32:23];
`ifdef FLOATMUL_SUBNORMAL_EN
    mag_o = e_out >= FP32_EXP_MAX ? FP32_INF[30:0] : sum[30:0];
`else
    mag_o = e_out >= FP32_EXP_MAX ? FP32_INF[30:0] : e_out <= 0 ? 31'd0 : sum[30:0];
`endif
  end
endmodule

// File: rtl/floatmul.sv
// floatmul: 3-stage IEEE-754 single-precision multiplier with valid/ready streams.
// Ports: clk, rst (sync, active-low), busy (work in flight),
//        a_*/b_* operand streams (joined, never consumed alone), o_* result stream.
// FLOATMUL_SUBNORMAL_EN enables subnormal inputs/results; default build is DAZ/FTZ.
module floatmul
  import floatmul_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  output logic     busy,
  input  logic     a_valid,
  input  float32_t a_payload,
  output logic     a_ready,
  input  logic     b_valid,
  input  float32_t b_payload,
  output logic     b_ready,
  output logic     o_valid,
  output float32_t o_payload,
  input  logic     o_ready
);
  logic      v1_q, v2_q, v3_q, ld1, ld2, ld3, fire;
  logic      nan, inf, zero;
  logic [30:0] mag;
  unpacked_t ua, ub;
  s1_t       s1_d, s1_q;
  s2_t       s2_d, s2_q;
  float32_t  o_d, o_q;

  assign ld3       = !v3_q || o_ready;
  assign ld2       = !v2_q || ld3;
  assign ld1       = !v1_q || ld2;
  assign fire      = a_valid && b_valid && ld1;
  assign a_ready   = b_valid && ld1;
  assign b_ready   = a_valid && ld1;
  assign busy      = v1_q || v2_q || v3_q;
  assign o_valid   = v3_q;
  assign o_payload = o_q;

  assign ua   = unpack(a_payload);
  assign ub   = unpack(b_payload);
  assign s1_d = '{sign:  a_payload.sign ^ b_payload.sign,
                  cls_a: ua.cls,
                  cls_b: ub.cls,
                  exp:   $signed(ua.exp) + $signed(ub.exp) - FP32_BIAS,
                  prod:  {24'd0, ua.sig} * {24'd0, ub.sig}};

  floatmul_round u_round (
    .prod_i (s1_q.prod),
    .exp_i  (s1_q.exp),
    .mag_o  (mag)
  );

  assign s2_d = '{sign: s1_q.sign, cls_a: s1_q.cls_a, cls_b: s1_q.cls_b, mag: mag};

  always_comb begin
    nan  = s2_q.cls_a == NAN || s2_q.cls_b == NAN ||
           (s2_q.cls_a == INF && s2_q.cls_b == ZERO) || (s2_q.cls_a == ZERO && s2_q.cls_b == INF);
    inf  = s2_q.cls_a == INF || s2_q.cls_b == INF;
    zero = s2_q.cls_a == ZERO || s2_q.cls_b == ZERO;
    o_d  = nan  ? FP32_QNAN :
           inf  ? {s2_q.sign, FP32_INF[30:0]} :
           zero ? {s2_q.sign, 31'd0} : {s2_q.sign, s2_q.mag};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      o_q  <= '0;
    end else begin
      if (ld1) v1_q <= fire;
      if (ld2) v2_q <= v1_q;
      if (ld3) v3_q <= v2_q;
      if (ld3 && v2_q) o_q <= o_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) s1_q <= s1_d;
    if (ld2 && v1_q) s2_q <= s2_d;
  end
endmodule

// File: tb/tb_floatmul.sv
// tb_floatmul: randomized scoreboard bench for floatmul against a real-arithmetic reference model.
module tb_floatmul;
  logic        clk = 1'b0, rst = 1'b0, busy, a_valid = 1'b0, a_ready, b_valid = 1'b0, b_ready;
  logic        o_valid, o_ready = 1'b1;
  logic [31:0] a_payload = '0, b_payload = '0, o_payload;
  int          tests = 0, fails = 0, accepted = 0, got = 0;
  bit          rand_ready = 1'b0;

  typedef struct packed { logic [31:0] a, b, e; } item_t;
  item_t sb[$];

`ifdef FLOATMUL_SUBNORMAL_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  floatmul dut (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .a_valid   (a_valid),
    .a_payload (a_payload),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_payload (b_payload),
    .b_ready   (b_ready),
    .o_valid   (o_valid),
    .o_payload (o_payload),
    .o_ready   (o_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic real pow2(int k);
    real r = 1.0;
    for (int i = 0; i < k; i++) r = r * 2.0;
    for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(logic [31:0] f);
    int e = int'(f[30:23]);
    return e == 0 ? real'(f[22:0]) * pow2(-149) : real'({1'b1, f[22:0]}) * pow2(e - 150);
  endfunction

  function automatic longint unsigned rne(longint unsigned v, int d);
    longint unsigned q = v >> d;
    longint unsigned r = v - (q << d);
    longint unsigned h = 64'd1 << (d - 1);
    if (r > h || (r == h && q[0])) q++;
    return q;
  endfunction

  // Exact product magnitude (fits a double) rounded once to float32.
  function automatic logic [30:0] r2f(real p);
    logic [63:0]     d = $realtobits(p);
    int              ef = int'(d[62:52]) - 1023 + 127;
    longint unsigned sig = {11'd0, 1'b1, d[51:0]};
    longint unsigned q;
    if (SUB && ef <= 0) begin
      int drop = 30 - ef;
      q = drop > 62 ? 64'd0 : rne(sig, drop);
      return q[30:0];
    end
    q = rne(sig, 29);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      ef++;
    end
    if (ef >= 255) return 31'h7F800000;
    if (ef <= 0) return 31'd0;
    return {ef[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
    bit s  = a[31] ^ b[31];
    bit an = (&a[30:23]) && (|a[22:0]);
    bit bn = (&b[30:23]) && (|b[22:0]);
    bit ai = (&a[30:23]) && !(|a[22:0]);
    bit bi = (&b[30:23]) && !(|b[22:0]);
    bit az = a[30:23] == 8'd0 && (!SUB || a[22:0] == 23'd0);
    bit bz = b[30:23] == 8'd0 && (!SUB || b[22:0] == 23'd0);
    if (an || bn || (ai && bz) || (bi && az)) return 32'h7FC00000;
    if (ai || bi) return {s, 31'h7F800000};
    if (az || bz) return {s, 31'd0};
    return {s, r2f(f2r(a) * f2r(b))};
  endfunction

  function automatic logic [31:0] rand_op();
    int          k = $urandom_range(9);
    logic [31:0] r = $urandom;
    if (k == 0) return r;
    if (k == 1) return {r[31], 8'h00, r[0] ? r[22:0] : 23'd0};
    if (k == 2) return {r[31], 8'hFF, r[1] ? r[22:0] : 23'd0};
    if (k == 3) return {r[31], 8'($urandom_range(1, 20)), r[22:0]};
    if (k == 4) return {r[31], 8'($urandom_range(230, 254)), r[22:0]};
    return {r[31], 8'($urandom_range(64, 190)), r[22:0]};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    int n = 0;
    a_payload = a;
    b_payload = b;
    a_valid = 1'b1;
    b_valid = 1'b1;
    @(negedge clk);
    while (!(a_ready && b_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: a_ready=%b b_ready=%b required 1", a_ready, b_ready);
    end else begin
      sb.push_back('{a, b, e});
      accepted++;
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    item_t it;
    if (rst && o_valid && o_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h required no output", o_payload);
      end else begin
        it = sb.pop_front();
        got++;
        check($sformatf("mul %h*%h", it.a, it.b), o_payload, it.e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  logic [31:0] dir [10][3] = '{
    '{32'h40000000, 32'h40400000, 32'h40C00000},
    '{32'hBFC00000, 32'h3FC00000, 32'hC0100000},
    '{32'h3F800001, 32'h3F800001, 32'h3F800002},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000},
    '{32'hFF800000, 32'h40000000, 32'hFF800000},
    '{32'h7FA00000, 32'h3F800000, 32'h7FC00000},
    '{32'h80000000, 32'h40000000, 32'h80000000},
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000},
    '{32'h00800000, 32'h3F000000, SUB ? 32'h00400000 : 32'h00000000},
    '{32'h7F800000, 32'hFF800000, 32'hFF800000}
  };

  initial begin
    int          prev;
    int          got0;
    logic [31:0] x, y;
    repeat (3) @(posedge clk);
    #1;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_o_payload", o_payload, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    send(dir[0][0], dir[0][1], dir[0][2]);
    check("lat_edge1", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2", 32'(o_valid), 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge3", 32'(o_valid), 32'd1);
    for (int i = 1; i < 10; i++) send(dir[i][0], dir[i][1], dir[i][2]);
    wait_drain();

    a_payload = 32'h40000000;
    a_valid = 1'b1;
    @(negedge clk);
    check("a_alone_a_ready", 32'(a_ready), 32'd0);
    check("a_alone_b_ready", 32'(b_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("a_alone_busy", 32'(busy), 32'd0);
    a_valid = 1'b0;

    o_ready = 1'b0;
    accepted = 0;
    got0 = got;
    fork
      for (int i = 0; i < 6; i++) begin
        logic [31:0] p, q;
        p = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
        q = {1'b1, 8'($urandom_range(100, 150)), 23'($urandom)};
        send(p, q, ref_mul(p, q));
      end
    join_none
    repeat (10) @(posedge clk);
    #1;
    check("bp_accepted", 32'(accepted), 32'd3);
    check("bp_a_ready", 32'(a_ready), 32'd0);
    check("bp_b_ready", 32'(b_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_o_valid", 32'(o_valid), 32'd1);
    o_ready = 1'b1;
    prev = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      prev = int'(o_valid && o_ready);
      @(posedge clk);
      #1;
    end
    check("bp_busy_clear", 32'(busy), 32'd0);
    check("bp_busy_fall_after_last", 32'(prev), 32'd1);
    check("bp_results", 32'(got - got0), 32'd6);

    x = 32'h40000000;
    send(x, x, 32'h40800000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_o_payload", o_payload, 32'd0);
    sb.delete();
    rst = 1'b1;

    rand_ready = 1'b1;
    fork
      while (rand_ready) begin
        @(posedge clk);
        #1;
        o_ready = $urandom_range(3) != 0;
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      x = rand_op();
      y = rand_op();
      send(x, y, ref_mul(x, y));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    o_ready = 1'b1;
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
